// File: rtl/ibex_mem_arb_pkg.sv
// Shared types for the Ibex instruction/data memory arbiter.
// Contents: owner IDs, arbiter FSM states, bus widths and the round-robin pick.
package ibex_mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Owner ID as stored in the response-ordering FIFO.
    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    // ARB: owner chosen freely each cycle. HOLD: owner locked until granted.
    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Round-robin pick: on a tie the port that was not granted last wins.
    function automatic owner_e rr_pick(input logic   instr_req,
                                       input logic   data_req,
                                       input owner_e last);
        if (instr_req && data_req) begin
            return (last == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
        end
        if (data_req) begin
            return OWN_DATA;
        end
        return OWN_INSTR;
    endfunction

endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// Owner-ID FIFO: remembers which port owns each granted but unanswered
// memory transaction, so in-order responses can be routed back.
// Ports: clk, rst (sync, active-high), push/wdata (1-bit ID), pop/rdata
// (head ID), full, empty.
module ibex_mem_arb_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic wdata,
    input  logic pop,
    output logic rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SLOTS = 1 << PTR_W;

    logic [SLOTS-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Arbitrates the Ibex instruction and data ports onto one memory port with
// zero added latency. Requests are forwarded combinationally from the current
// owner; an owner-ID FIFO routes in-order responses back to the right port.
// Ports: clk, rst (sync, active-high); instr_* core instruction port;
// data_* core data port; mem_* shared memory port; protocol_err_o sticky flag
// for a memory response with nothing outstanding.
module ibex_mem_arbiter
    import ibex_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic              instr_err_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,

    output logic              protocol_err_o
);

    arb_state_e state_q, state_d;
    owner_e     hold_owner_q, hold_owner_d;
    owner_e     last_q, last_d;
    logic       protocol_err_q, protocol_err_d;

    owner_e     owner;
    logic       owner_req;
    logic       grant;
    logic       resp_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;

    ibex_mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .wdata (owner),
        .pop   (resp_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB;
            hold_owner_q   <= OWN_INSTR;
            last_q         <= OWN_DATA;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_owner_q   <= hold_owner_d;
            last_q         <= last_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    // Ownership, request forwarding, response routing and next state.
    always_comb begin
        state_d        = state_q;
        hold_owner_d   = hold_owner_q;
        last_d         = last_q;
        protocol_err_d = protocol_err_q;

        owner     = (state_q == HOLD) ? hold_owner_q
                                      : rr_pick(instr_req_i, data_req_i, last_q);
        owner_req = (owner == OWN_DATA) ? data_req_i : instr_req_i;

        // Full blocks issue even if a response pops an entry this cycle.
        mem_req_o   = owner_req & ~fifo_full & ~rst;
        grant       = mem_req_o & mem_gnt_i;
        instr_gnt_o = grant & (owner == OWN_INSTR);
        data_gnt_o  = grant & (owner == OWN_DATA);

        if (owner == OWN_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_be_o    = {BE_W{1'b1}};
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = '0;
        end

        resp_pop       = mem_rvalid_i & ~fifo_empty & ~rst;
        instr_rvalid_o = resp_pop & (fifo_head == OWN_INSTR);
        data_rvalid_o  = resp_pop & (fifo_head == OWN_DATA);
        instr_err_o    = instr_rvalid_o & mem_err_i;
        data_err_o     = data_rvalid_o & mem_err_i;
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
        protocol_err_o = protocol_err_q & ~rst;

        if (mem_rvalid_i && fifo_empty && !rst) begin
            protocol_err_d = 1'b1;
        end

        if (grant) begin
            last_d = owner;
        end

        // Lock the owner while a request waits so the address stays stable.
        case (state_q)
            ARB: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d      = HOLD;
                    hold_owner_d = owner;
                end
            end
            HOLD: begin
                if (grant) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter (MAX_OUTSTANDING=2).
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. Granted owners go into a scoreboard queue and are checked
// against the port that raises rvalid when the bench returns a response.
module tb_ibex_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic        protocol_err_o;

    int total = 0;
    int bad   = 0;
    logic sb_q[$];   // expected owner of each outstanding response (0=instr,1=data)

    always #5 clk = ~clk;

    ibex_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .protocol_err_o (protocol_err_o)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_req_i = 1'b1; data_req_i = 1'b1;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
             instr_err_o, data_err_o, protocol_err_o} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o,
                      data_rvalid_o, instr_err_o, data_err_o, protocol_err_o});
        end
        total++;
        if (instr_rdata_o !== 32'h1234_5678 || data_rdata_o !== 32'h1234_5678) begin
            bad++;
            $display("FAIL reset_rdata_pass got=%h/%h exp=12345678",
                     instr_rdata_o, data_rdata_o);
        end
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle got req=%b perr=%b exp=0/0",
                     mem_req_o, protocol_err_o);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic exp_own;
        logic exp;
        instr_addr_i = 32'h1000; data_addr_i = 32'h2000;
        data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = 32'h0;
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = (i > 0);
            mem_rdata_i  = 32'hA0 + 32'(i);
            @(negedge clk);
            if (mem_rvalid_i) begin
                exp = sb_q.pop_front();
                total++;
                if (instr_rvalid_o !== ~exp || data_rvalid_o !== exp) begin
                    bad++;
                    $display("FAIL rr_resp%0d got i/d=%b%b exp_owner=%b",
                             i, instr_rvalid_o, data_rvalid_o, exp);
                end
            end
            exp_own = 1'(i % 2);
            total++;
            if ({instr_gnt_o, data_gnt_o} !== (exp_own ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL rr_grant%0d got i/d=%b%b exp_owner=%b",
                         i, instr_gnt_o, data_gnt_o, exp_own);
            end
            total++;
            if (mem_addr_o !== (exp_own ? 32'h2000 : 32'h1000)) begin
                bad++;
                $display("FAIL rr_addr%0d got=%h exp_owner=%b", i, mem_addr_o, exp_own);
            end
            sb_q.push_back(exp_own);
            next_cycle();
        end
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp = sb_q.pop_front();
            total++;
            if (instr_rvalid_o !== ~exp || data_rvalid_o !== exp) begin
                bad++;
                $display("FAIL rr_drain got i/d=%b%b exp_owner=%b",
                         instr_rvalid_o, data_rvalid_o, exp);
            end
            next_cycle();
        end
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_hold();
        logic exp;
        instr_req_i = 1'b0; instr_addr_i = 32'h200;
        data_req_i = 1'b1; data_addr_i = 32'h100; data_we_i = 1'b1;
        data_be_i = 4'h3; data_wdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) instr_req_i = 1'b1;
            @(negedge clk);
            total++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b1 ||
                instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin
                bad++;
                $display("FAIL hold_wait%0d got req=%b addr=%h we=%b gnt=%b%b exp 1/100/1/00",
                         c, mem_req_o, mem_addr_o, mem_we_o, instr_gnt_o, data_gnt_o);
            end
            next_cycle();
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        total++;
        if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0 || mem_addr_o !== 32'h100 ||
            mem_wdata_o !== 32'hDEAD_BEEF || mem_be_o !== 4'h3) begin
            bad++;
            $display("FAIL hold_grant got gnt=%b%b addr=%h wdata=%h be=%h exp 01/100/deadbeef/3",
                     instr_gnt_o, data_gnt_o, mem_addr_o, mem_wdata_o, mem_be_o);
        end
        sb_q.push_back(1'b1);
        next_cycle();
        data_req_i = 1'b0;
        @(negedge clk);
        total++;
        if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_we_o !== 1'b0 ||
            mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin
            bad++;
            $display("FAIL hold_instr_after got gnt=%b addr=%h we=%b be=%h wdata=%h exp 1/200/0/f/0",
                     instr_gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        end
        sb_q.push_back(1'b0);
        next_cycle();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        while (sb_q.size() > 0) begin
            mem_rdata_i = $urandom;
            @(negedge clk);
            exp = sb_q.pop_front();
            total++;
            if (instr_rvalid_o !== ~exp || data_rvalid_o !== exp) begin
                bad++;
                $display("FAIL hold_drain got i/d=%b%b exp_owner=%b",
                         instr_rvalid_o, data_rvalid_o, exp);
            end
            next_cycle();
        end
        mem_rvalid_i = 1'b0; data_we_i = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        logic exp;
        data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (instr_gnt_o !== 1'b1) begin
                bad++;
                $display("FAIL limit_grant%0d got=%b exp=1", c, instr_gnt_o);
            end
            sb_q.push_back(1'b0);
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL limit_full got req=%b gnt=%b exp=0/0", mem_req_o, instr_gnt_o);
        end
        next_cycle();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
        @(negedge clk);
        exp = sb_q.pop_front();
        total++;
        if (mem_req_o !== 1'b0 || instr_rvalid_o !== ~exp || instr_rdata_o !== 32'h55) begin
            bad++;
            $display("FAIL limit_pop got req=%b rvalid=%b rdata=%h exp 0/1/55",
                     mem_req_o, instr_rvalid_o, instr_rdata_o);
        end
        next_cycle();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL limit_resume got req=%b gnt=%b exp=1/1", mem_req_o, instr_gnt_o);
        end
        sb_q.push_back(1'b0);
        next_cycle();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            exp = sb_q.pop_front();
            total++;
            if (instr_rvalid_o !== ~exp || data_rvalid_o !== exp) begin
                bad++;
                $display("FAIL limit_drain got i/d=%b%b exp_owner=%b",
                         instr_rvalid_o, data_rvalid_o, exp);
            end
            next_cycle();
        end
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_response_order();
        logic exp;
        instr_req_i = 1'b1; data_req_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk);
        total++;
        if (instr_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL order_gnt_instr got=%b exp=1", instr_gnt_o);
        end
        sb_q.push_back(1'b0);
        next_cycle();
        instr_req_i = 1'b0; data_req_i = 1'b1;
        @(negedge clk);
        total++;
        if (data_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL order_gnt_data got=%b exp=1", data_gnt_o);
        end
        sb_q.push_back(1'b1);
        next_cycle();
        data_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA; mem_err_i = 1'b0;
        @(negedge clk);
        exp = sb_q.pop_front();
        total++;
        if (instr_rvalid_o !== ~exp || data_rvalid_o !== exp || instr_rdata_o !== 32'hA) begin
            bad++;
            $display("FAIL order_resp_a got i/d=%b%b rdata=%h exp_owner=%b rdata=a",
                     instr_rvalid_o, data_rvalid_o, instr_rdata_o, exp);
        end
        next_cycle();
        mem_rdata_i = 32'hB; mem_err_i = 1'b1;
        @(negedge clk);
        exp = sb_q.pop_front();
        total++;
        if (instr_rvalid_o !== ~exp || data_rvalid_o !== exp || data_rdata_o !== 32'hB ||
            data_err_o !== 1'b1 || instr_err_o !== 1'b0) begin
            bad++;
            $display("FAIL order_resp_b got i/d=%b%b rdata=%h err i/d=%b%b exp_owner=%b rdata=b err=01",
                     instr_rvalid_o, data_rvalid_o, data_rdata_o, instr_err_o, data_err_o, exp);
        end
        next_cycle();
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    endtask

    task automatic test_spurious();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE;
        @(negedge clk);
        total++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL spur_no_rvalid got i/d=%b%b exp=00", instr_rvalid_o, data_rvalid_o);
        end
        next_cycle();
        mem_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (protocol_err_o !== 1'b1) begin
                bad++;
                $display("FAIL spur_sticky%0d got=%b exp=1", c, protocol_err_o);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (protocol_err_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_perr_clear got=%b exp=0", protocol_err_o);
        end
        next_cycle();
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({instr_gnt_o, data_gnt_o} !== ((c == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL mid_grant%0d got i/d=%b%b", c, instr_gnt_o, data_gnt_o);
            end
            sb_q.push_back(1'(c));
            next_cycle();
        end
        rst = 1'b1; mem_rvalid_i = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
            bad++;
            $display("FAIL mid_rst_outputs got=%b exp=00000",
                     {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
        end
        sb_q.delete();
        next_cycle();
        rst = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
        @(negedge clk);
        total++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || protocol_err_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale_resp got i/d=%b%b perr=%b exp=00/0",
                     instr_rvalid_o, data_rvalid_o, protocol_err_o);
        end
        next_cycle();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++;
        if (protocol_err_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_perr_set got=%b exp=1", protocol_err_o);
        end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF;
        data_addr_i = '0; data_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        test_reset();
        test_round_robin();
        test_hold();
        test_outstanding_limit();
        test_response_order();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish within 100000ns");
        $fatal(1);
    end

endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max accepted-but-unanswered memory transactions (1..4).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1: core instruction port (req/gnt/rvalid).
REQ-005 SHALL have ports data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1: core data port.
REQ-006 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32, mem_gnt_i in 1, mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1: shared single memory port.
REQ-007 SHALL have port protocol_err_o  out  1  sticky flag, spurious mem_rvalid_i seen.

Function
REQ-008 SHALL select one owner per cycle; mem_req_o = owner's req AND NOT owner-FIFO full.
REQ-009 SHALL drive mem_we_o/be_o/addr_o/wdata_o combinationally from owner; instr owner: we=0, be=4'hF, wdata=0.
REQ-010 SHALL route mem_gnt_i only to the owner's gnt; the non-owner's gnt SHALL be 0.
REQ-011 SHALL round-robin arbitrate: both requesting in ARB state -> winner is the port not granted last; single requester wins.
REQ-012 SHALL use states ARB (free selection) and HOLD (owner locked); ARB->HOLD when mem_req_o=1 and mem_gnt_i=0; HOLD->ARB on mem_gnt_i=1.
REQ-013 SHALL, in HOLD, keep owner fixed regardless of the other port's req, so address stays stable until grant.
REQ-014 SHALL, on each grant (mem_req_o & mem_gnt_i), push owner ID (0=instr,1=data) into owner FIFO and update last-granted.
REQ-015 SHALL, on mem_rvalid_i with FIFO non-empty, pop the head and pulse head-owner's rvalid the same cycle, with rdata=mem_rdata_i and err=mem_err_i; the other port's rvalid=0.
REQ-016 SHALL drive both rdata outputs with mem_rdata_i at all times (validity qualified by rvalid only).
REQ-017 SHALL block issue (mem_req_o=0) when FIFO holds MAX_OUTSTANDING entries, even if a pop occurs that cycle.
REQ-018 SHALL allow push and pop in the same cycle when not full; occupancy unchanged.
REQ-019 SHALL, on mem_rvalid_i with FIFO empty, assert no core rvalid and set protocol_err_o until reset.
REQ-020 SHALL add zero latency on request and response paths (pure forwarding plus registered ownership).
REQ-021 SHALL tolerate mem_gnt_i in the same cycle as mem_req_o first rises (ARB->ARB, no HOLD).

Reset
REQ-022 SHALL, while rst=1, force state ARB, FIFO empty, last-granted=data (instr wins first tie), protocol_err_o=0.
REQ-023 SHALL, while rst=1, drive all gnt, rvalid, err and mem_req_o outputs to 0.
REQ-024 SHALL discard outstanding transactions on reset mid-operation; responses arriving after reset deassertion count as spurious (REQ-019).

Structure
REQ-025 SHALL place owner-ID enum (OWN_INSTR, OWN_DATA) and state enum (ARB, HOLD) in package ibex_mem_arb_pkg.
REQ-026 SHALL implement owner FIFO as sub-module ibex_mem_arb_id_fifo (depth MAX_OUTSTANDING, width 1, full/empty flags).

Verification
REQ-027 SHALL cover: reset then instr_req=1, data_req=1, mem_gnt=1 each cycle -> grants alternate instr,data,instr,data.
REQ-028 SHALL cover: data_req addr 0x100, mem_gnt=0 for 3 cycles while instr_req rises -> mem_addr_o stays 0x100, instr_gnt_o=0 until data granted.
REQ-029 SHALL cover: MAX_OUTSTANDING=2, two grants, no rvalid -> mem_req_o=0 on third request; one rvalid -> issue resumes next cycle.
REQ-030 SHALL cover: grant instr then data, rvalid with rdata 0xA then 0xB -> instr_rvalid_o with 0xA, then data_rvalid_o with 0xB.
REQ-031 SHALL cover: mem_rvalid_i=1 with empty FIFO -> no core rvalid, protocol_err_o=1 held until rst.
REQ-032 SHALL cover: rst asserted with 2 outstanding -> FIFO empty, outputs 0; subsequent rvalid sets protocol_err_o.
